// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter
//
// Shares one cacheline adapter between the I-cache (read-only) and the D-cache
// (read/write). One requester owns the adapter at a time. Its address, command
// and write line are latched when it is granted and held until the adapter
// completes. The returned line and a one-cycle resp pulse go to the owner only.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   - a tie in IDLE goes to the requester that was not served last.
//               After reset the first tie goes to the D-cache.
//   undefined - fixed priority: the D-cache always wins a tie.
//
// Ports:
//   clk, rst_n                     clock (rising edge), synchronous active-low reset
//   i_addr, i_read                 I-cache request (level, held until i_resp)
//   i_rdata, i_resp                I-cache response line and completion pulse
//   d_addr, d_read, d_write        D-cache request (level, held until d_resp)
//   d_wdata                        D-cache writeback line
//   d_rdata, d_resp                D-cache response line and completion pulse
//   m_addr, m_read, m_write        adapter command (driven only while busy)
//   m_wdata                        adapter write line
//   m_rdata, m_resp                adapter return line and completion pulse
//   grant                          00 none, 01 I-cache, 10 D-cache

module cacheline_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    output logic              m_write,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        StIdle,
        StIBusy,
        StDBusy,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                owner_d_q, owner_d_d;     // 1: D-cache owns the transaction
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic                lat_rd_q, lat_rd_d;
    logic                lat_wr_q, lat_wr_d;
    logic [LINE_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic d_req;
    logic pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;                       // 1: D-cache was served last

    always_comb begin
        d_req  = d_read | d_write;
        // Tie goes to D only if I was served last; reset leaves last = I.
        pick_d = d_req & (~i_read | ~last_d_q);
    end
`else
    always_comb begin
        d_req  = d_read | d_write;
        pick_d = d_req;
    end
`endif

    // Next-state and latch update.
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        lat_addr_d  = lat_addr_q;
        lat_rd_d    = lat_rd_q;
        lat_wr_d    = lat_wr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_read || d_req) begin
                    owner_d_d   = pick_d;
                    lat_addr_d  = pick_d ? d_addr : i_addr;
                    // Writeback takes precedence when D asserts both commands.
                    lat_wr_d    = pick_d & d_write;
                    lat_rd_d    = pick_d ? (d_read & ~d_write) : 1'b1;
                    lat_wdata_d = pick_d ? d_wdata : '0;
                    state_d     = pick_d ? StDBusy : StIBusy;
                end
            end
            StIBusy, StDBusy: begin
                if (m_resp) begin
                    rdata_d = m_rdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = owner_d_q;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_d_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_rd_q    <= 1'b0;
            lat_wr_q    <= 1'b0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            lat_addr_q  <= lat_addr_d;
            lat_rd_q    <= lat_rd_d;
            lat_wr_q    <= lat_wr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    // Outputs decode from the state only, so the adapter command drops in the
    // same cycle m_resp moves the FSM into DONE.
    always_comb begin
        m_addr  = '0;
        m_read  = 1'b0;
        m_write = 1'b0;
        m_wdata = '0;
        i_rdata = '0;
        i_resp  = 1'b0;
        d_rdata = '0;
        d_resp  = 1'b0;
        grant   = 2'b00;

        unique case (state_q)
            StIBusy, StDBusy: begin
                m_addr  = lat_addr_q;
                m_read  = lat_rd_q;
                m_write = lat_wr_q;
                m_wdata = lat_wdata_q;
                grant   = (state_q == StDBusy) ? 2'b10 : 2'b01;
            end
            StDone: begin
                if (owner_d_q) begin
                    d_resp  = 1'b1;
                    d_rdata = rdata_q;
                    grant   = 2'b10;
                end else begin
                    i_resp  = 1'b1;
                    i_rdata = rdata_q;
                    grant   = 2'b01;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
module tb_cacheline_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr;
    logic          i_read;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] m_addr;
    logic          m_read;
    logic          m_write;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata;
    logic          m_resp;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    cacheline_mem_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_addr (i_addr),
        .i_read (i_read),
        .i_rdata(i_rdata),
        .i_resp (i_resp),
        .d_addr (d_addr),
        .d_read (d_read),
        .d_write(d_write),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_resp (d_resp),
        .m_addr (m_addr),
        .m_read (m_read),
        .m_write(m_write),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_resp (m_resp),
        .grant  (grant)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // All sampling and driving happens on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, grant, 2'b00);
        chk({tag, ".m_read"}, m_read, 1'b0);
        chk({tag, ".m_write"}, m_write, 1'b0);
        chk({tag, ".m_addr"}, m_addr, '0);
        chk({tag, ".m_wdata"}, m_wdata, '0);
        chk({tag, ".i_resp"}, i_resp, 1'b0);
        chk({tag, ".d_resp"}, d_resp, 1'b0);
        chk({tag, ".i_rdata"}, i_rdata, '0);
        chk({tag, ".d_rdata"}, d_rdata, '0);
    endtask

    task automatic wait_cmd(input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m_read || m_write) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s.cmd_timeout: got no command, want one within 8 cycles", tag);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < int'(LW / 32); k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    typedef struct {
        logic       ir;
        logic       dr;
        logic       dw;
        logic [1:0] g;
        logic       rd;
        logic       wr;
    } vec_t;

    vec_t          vecs[6];
    bit            ok;
    int            cnt;
    logic [LW-1:0] wd0;
    logic [LW-1:0] rd_line;
    logic [1:0]    tie_exp[4];

    // Random-phase reference model state.
    bit            ip, dp, win_d, last_d;
    logic [AW-1:0] ia, da;
    int unsigned   dcmd;                 // 0 read, 1 write, 2 read+write
    logic [LW-1:0] wd;
    logic          extra;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        // Table: request pattern from IDLE -> expected grant and adapter command.
        // History before the table leaves D as the last one served.
        vecs[0] = '{ir: 1, dr: 0, dw: 0, g: 2'b01, rd: 1, wr: 0};
        vecs[1] = '{ir: 0, dr: 1, dw: 0, g: 2'b10, rd: 1, wr: 0};
        vecs[2] = '{ir: 0, dr: 1, dw: 1, g: 2'b10, rd: 0, wr: 1};
        vecs[3] = '{ir: 0, dr: 0, dw: 1, g: 2'b10, rd: 0, wr: 1};
`ifdef ARB_ROUND_ROBIN_EN
        vecs[4] = '{ir: 1, dr: 1, dw: 0, g: 2'b01, rd: 1, wr: 0};
        tie_exp[0] = 2'b10; tie_exp[1] = 2'b01; tie_exp[2] = 2'b10; tie_exp[3] = 2'b01;
`else
        vecs[4] = '{ir: 1, dr: 1, dw: 0, g: 2'b10, rd: 1, wr: 0};
        tie_exp[0] = 2'b10; tie_exp[1] = 2'b10; tie_exp[2] = 2'b10; tie_exp[3] = 2'b10;
`endif
        vecs[5] = '{ir: 1, dr: 0, dw: 1, g: 2'b10, rd: 0, wr: 1};

        i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_wdata = '0; m_rdata = '0; m_resp = 1'b0; rst_n = 1'b0;

        // Reset held two cycles with an I request pending.
        i_addr = 32'h0000_1000;
        i_read = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk("rst_exit.grant", grant, 2'b01);
        chk("rst_exit.m_read", m_read, 1'b1);
        chk("rst_exit.m_write", m_write, 1'b0);
        chk("rst_exit.m_addr", m_addr, 32'h0000_1000);

        // I read alone: adapter answers after 6 cycles of m_read.
        cnt = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (m_read) cnt++;
            chk("iread.i_resp_early", i_resp, 1'b0);
        end
        chk("iread.m_read_cycles", cnt, 6);
        m_resp  = 1'b1;
        m_rdata = {32{8'hAA}};
        tick();
        chk("iread.i_resp", i_resp, 1'b1);
        chk("iread.i_rdata", i_rdata, {32{8'hAA}});
        chk("iread.d_resp", d_resp, 1'b0);
        chk("iread.d_rdata", d_rdata, '0);
        chk("iread.m_read_drop", m_read, 1'b0);
        chk("iread.done_grant", grant, 2'b01);
        m_resp  = 1'b0;
        m_rdata = '0;
        i_read  = 1'b0;
        tick();
        chk_idle("iread.after");

        // D writeback; inputs scrambled while busy must not reach the adapter.
        wd0     = {8{32'h1234_5678}};
        d_write = 1'b1;
        d_addr  = 32'h8000_0040;
        d_wdata = wd0;
        tick();
        chk("dwb.grant", grant, 2'b10);
        chk("dwb.m_write", m_write, 1'b1);
        chk("dwb.m_read", m_read, 1'b0);
        chk("dwb.m_addr", m_addr, 32'h8000_0040);
        chk("dwb.m_wdata", m_wdata, wd0);
        d_wdata = ~wd0;
        d_addr  = 32'hDEAD_0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dwb.hold_wdata", m_wdata, wd0);
            chk("dwb.hold_addr", m_addr, 32'h8000_0040);
            chk("dwb.hold_write", m_write, 1'b1);
        end
        m_resp  = 1'b1;
        m_rdata = rand_line();
        tick();
        chk("dwb.d_resp", d_resp, 1'b1);
        chk("dwb.i_resp", i_resp, 1'b0);
        chk("dwb.i_rdata", i_rdata, '0);
        chk("dwb.m_write_drop", m_write, 1'b0);
        chk("dwb.done_grant", grant, 2'b10);
        m_resp  = 1'b0;
        d_write = 1'b0;
        tick();
        chk_idle("dwb.after");

        // Table-driven single transactions.
        for (int r = 0; r < 6; r++) begin
            i_read  = vecs[r].ir;
            d_read  = vecs[r].dr;
            d_write = vecs[r].dw;
            i_addr  = $urandom();
            d_addr  = $urandom();
            d_wdata = rand_line();
            tick();
            chk("vec.grant", grant, vecs[r].g);
            chk("vec.m_read", m_read, vecs[r].rd);
            chk("vec.m_write", m_write, vecs[r].wr);
            chk("vec.m_addr", m_addr, (vecs[r].g == 2'b10) ? d_addr : i_addr);
            if (vecs[r].g == 2'b10) chk("vec.m_wdata", m_wdata, d_wdata);
            rd_line = rand_line();
            m_resp  = 1'b1;
            m_rdata = rd_line;
            tick();
            chk("vec.i_resp", i_resp, vecs[r].g[0]);
            chk("vec.d_resp", d_resp, vecs[r].g[1]);
            if (vecs[r].g == 2'b01) begin
                chk("vec.i_rdata", i_rdata, rd_line);
                chk("vec.d_rdata_zero", d_rdata, '0);
            end else begin
                chk("vec.i_rdata_zero", i_rdata, '0);
                if (vecs[r].rd) chk("vec.d_rdata", d_rdata, rd_line);
            end
            m_resp = 1'b0;
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            tick();
            chk("vec.idle_grant", grant, 2'b00);
        end

        // Reset in the middle of a D writeback.
        d_write = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = rand_line();
        tick();
        chk("midrst.m_write", m_write, 1'b1);
        tick();
        rst_n   = 1'b0;
        d_write = 1'b0;
        tick();
        chk("midrst.m_write_off", m_write, 1'b0);
        chk("midrst.grant", grant, 2'b00);
        chk("midrst.d_resp", d_resp, 1'b0);
        rst_n   = 1'b1;
        m_resp  = 1'b1;
        m_rdata = rand_line();
        tick();
        chk("midrst.stray_i_resp", i_resp, 1'b0);
        chk("midrst.stray_d_resp", d_resp, 1'b0);
        m_resp = 1'b0;
        tick();
        chk_idle("midrst.after");

        // Continuous tie straight after reset.
        i_read = 1'b1;
        d_read = 1'b1;
        i_addr = 32'h0000_2000;
        d_addr = 32'h0000_3000;
        cnt    = 0;
        for (int t = 0; t < 4; t++) begin
            wait_cmd("tie", ok);
            if (!ok) break;
            chk("tie.grant", grant, tie_exp[t]);
            chk("tie.m_addr", m_addr, (tie_exp[t] == 2'b10) ? 32'h0000_3000 : 32'h0000_2000);
            tick();
            m_resp = 1'b1;
            tick();
            m_resp = 1'b0;
            if (i_resp) cnt++;
            chk("tie.i_resp", i_resp, tie_exp[t][0]);
            chk("tie.d_resp", d_resp, tie_exp[t][1]);
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie.i_resp_count", cnt, 2);
`else
        chk("tie.i_resp_count", cnt, 0);
`endif
        i_read = 1'b0;
        d_read = 1'b0;

        // Randomized traffic against a transaction-level model.
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        last_d = 1'b0;
        ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dcmd = 0; wd = '0;
        for (int it = 0; it < 150; it++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1; ia = $urandom();
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1; da = $urandom(); dcmd = $urandom_range(0, 2); wd = rand_line();
            end
            if (!ip && !dp) begin
                ip = 1'b1; ia = $urandom();
            end
            i_read  = ip;
            i_addr  = ia;
            d_read  = dp && (dcmd != 1);
            d_write = dp && (dcmd != 0);
            d_addr  = da;
            d_wdata = wd;
`ifdef ARB_ROUND_ROBIN_EN
            win_d = dp && (!ip || !last_d);
`else
            win_d = dp;
`endif
            if (it > 0) begin
                tick();
                m_resp = 1'b0;
                chk("rnd.idle_grant", grant, 2'b00);
                chk("rnd.idle_i_resp", i_resp, 1'b0);
                chk("rnd.idle_d_resp", d_resp, 1'b0);
            end
            wait_cmd("rnd", ok);
            if (!ok) break;
            for (int b = 0; b <= int'($urandom_range(0, 4)); b++) begin
                chk("rnd.grant", grant, win_d ? 2'b10 : 2'b01);
                chk("rnd.m_addr", m_addr, win_d ? da : ia);
                chk("rnd.m_read", m_read, win_d ? (dcmd == 0) : 1'b1);
                chk("rnd.m_write", m_write, win_d ? (dcmd != 0) : 1'b0);
                if (win_d) chk("rnd.m_wdata", m_wdata, wd);
                if (win_d) begin
                    d_addr = $urandom(); d_wdata = rand_line();
                end else begin
                    i_addr = $urandom();
                end
                tick();
            end
            rd_line = rand_line();
            m_resp  = 1'b1;
            m_rdata = rd_line;
            tick();
            chk("rnd.i_resp", i_resp, !win_d);
            chk("rnd.d_resp", d_resp, win_d);
            chk("rnd.done_grant", grant, win_d ? 2'b10 : 2'b01);
            chk("rnd.cmd_drop", m_read | m_write, 1'b0);
            if (win_d) begin
                chk("rnd.i_rdata_zero", i_rdata, '0);
                if (dcmd == 0) chk("rnd.d_rdata", d_rdata, rd_line);
                dp = 1'b0;
            end else begin
                chk("rnd.i_rdata", i_rdata, rd_line);
                chk("rnd.d_rdata_zero", d_rdata, '0);
                ip = 1'b0;
            end
            last_d = win_d;
            // An m_resp lingering into DONE must be ignored.
            extra  = 1'($urandom_range(0, 1));
            m_resp = extra;
        end
        m_resp = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Shares the single cacheline adapter (256-bit line port) between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the cacheline adapter.
- Grants one requester at a time and latches that requester's address, command and write data for the whole transaction.
- Returns the adapter's line data and a one-cycle response to the granted requester only.

Parameters:
- ADDR_W, 32, address width of all ports.
- LINE_W, 256, cacheline width of all data ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_addr  in  ADDR_W  I-cache line address.
- i_read  in  1  I-cache read request; level, held until i_resp.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_addr  in  ADDR_W  D-cache line address.
- d_read  in  1  D-cache read request; level, held until d_resp.
- d_write  in  1  D-cache writeback request; level, held until d_resp.
- d_wdata  in  LINE_W  D-cache writeback line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- m_addr  out  ADDR_W  address to adapter.
- m_read  out  1  read command to adapter.
- m_write  out  1  write command to adapter.
- m_wdata  out  LINE_W  write line to adapter.
- m_rdata  in  LINE_W  line from adapter; valid when m_resp=1.
- m_resp  in  1  adapter completion pulse.
- grant  out  2  status: 00 none, 01 I-cache, 10 D-cache.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, last_grant=I.
  - All latches are cleared to 0.
  - All outputs are 0.
  - Reset mid-transaction abandons the transaction without issuing a resp; the adapter is reset by the same reset.
- D-cache command: d_write has priority over d_read. d_req = d_read | d_write.
- States and transitions:
  - IDLE:
    - If any request is pending, arbitrate (see below).
    - At the edge, latch the winner's addr, command (rd/wr) and wdata (D only) into lat_addr/lat_rd/lat_wr/lat_wdata.
    - Go to I_BUSY or D_BUSY.
    - No request: stay in IDLE.
  - I_BUSY / D_BUSY:
    - Drive m_addr=lat_addr, m_read=lat_rd, m_wdata=lat_wdata, m_write=lat_wr.
    - Hold these every cycle until m_resp=1.
    - On m_resp: capture m_rdata into rdata_q, update last_grant to the owner, go to DONE.
    - Because m_read/m_write decode from the BUSY states only, they drop in the same cycle m_resp is sampled.
  - DONE, one cycle:
    - Assert i_resp or d_resp for the owner only.
    - Drive that requester's rdata from rdata_q (write transactions return rdata_q, contents don't care).
    - The non-owner's resp=0 and its rdata=0.
    - Next state is IDLE.
- Latency: grant edge to first m_read/m_write = 1 cycle. Adapter resp to cache resp = 1 cycle (registered).
- Changes to the requester's inputs while BUSY are ignored; the latched values are used.
- A request arriving during BUSY/DONE waits. It is arbitrated in IDLE, so the minimum gap between transactions is 1 idle cycle.
- m_resp while IDLE or DONE is ignored and has no effect.
- grant = 01/10 during BUSY and DONE, 00 in IDLE.
- m_addr, m_wdata and the command lines are 0 in IDLE and DONE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both request in IDLE, grant the requester not equal to last_grant (alternation). After reset the first tie goes to D.
- Undefined: fixed priority. D-cache always wins ties, last_grant is unused, and I-cache may starve under continuous D traffic.
- Single requester is granted immediately in both modes.

Test Plan:
- Reset → hold rst_n=0 2 cycles with i_read=1 → all outputs 0, grant=00; rst_n=1 → next edge grant=01, m_read=1, m_addr=i_addr.
- I read alone: i_addr=0x0000_1000, adapter m_resp with m_rdata=0xAAAA…A after 6 cycles → m_read held 6 cycles; next cycle i_resp=1 for exactly one cycle with i_rdata=0xAAAA…A; d_resp stays 0.
- D writeback: d_write=1, d_addr=0x8000_0040, d_wdata=0x1234…; change d_wdata mid-burst → m_write=1, m_wdata stays the latched value until m_resp; d_resp pulse 1 cycle later.
- Simultaneous d_read and d_write=1 → m_write=1, m_read=0.
- Tie, ARB_ROUND_ROBIN_EN defined: i_read and d_read held continuously for 4 transactions → grant order D,I,D,I. Macro undefined → D,D,D,D and i_resp never asserts.
- Reset mid-transaction: assert rst_n=0 while D_BUSY → next edge IDLE, m_write=0, no d_resp; a later m_resp pulse in IDLE produces no i_resp/d_resp.
